mnist_accuracy_monitor: RTL

//  On-chip scoreboard at the output end of the pseudo_linear classifier path.

---
 rtl/mnist_accuracy_monitor_if.sv | 12 +
 rtl/mnist_accuracy_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mnist_accuracy_monitor_if.sv
// Sample handshake between the classifier output stage and the accuracy monitor.
// The classifier side drives pred/label/in_last with in_valid; the monitor answers with in_ready.
interface mnist_accuracy_monitor_if;
   logic in_valid;
   logic in_ready;
   logic pred;
   logic label;
   logic in_last;

   modport master (output in_valid, output pred, output label, output in_last, input in_ready);
   modport slave  (input in_valid, input pred, input label, input in_last, output in_ready);
endinterface

// File: rtl/mnist_accuracy_monitor.sv
// Counts accepted (prediction, label) pairs over a test pass, then reports accuracy in basis
// points through a restoring shift-subtract divider that produces one quotient bit per cycle.
module mnist_accuracy_monitor #(
   parameter int CNT_W  = 14,
   parameter int N_TEST = 2115,
   parameter int ACC_W  = 14
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   mnist_accuracy_monitor_if.slave      smp,
   output logic [CNT_W-1:0]             total_cnt,
   output logic [CNT_W-1:0]             correct_cnt,
   output logic [ACC_W-1:0]             acc_bp,
   output logic                         busy,
   output logic                         done
);

   localparam int NUM_W  = CNT_W + 14;
   localparam int DIV_CW = $clog2(NUM_W);
   localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(N_TEST);
   localparam logic [DIV_CW-1:0] DIV_LAST  = DIV_CW'(NUM_W - 1);
   localparam logic [NUM_W-1:0]  BP_SCALE  = NUM_W'(10000);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      DIVIDE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state;
   logic [NUM_W-1:0]    quo;
   logic [CNT_W-1:0]    rem;
   logic [DIV_CW-1:0]   div_cnt;

   logic                accept;
   logic                match;
   logic                pass_end;
   logic [CNT_W-1:0]    total_inc;
   logic [CNT_W-1:0]    correct_inc;
   logic [CNT_W:0]      rem_sh;
   logic                ge;
   logic [CNT_W-1:0]    rem_nx;
   logic [NUM_W-1:0]    quo_nx;

   assign accept      = (state == COUNT) && smp.in_valid && smp.in_ready;
   assign match       = (smp.pred == smp.label);
   assign total_inc   = total_cnt + CNT_W'(1);
   assign correct_inc = correct_cnt + CNT_W'(match);
   assign pass_end    = smp.in_last || (total_inc == N_LAST);

   // One restoring-divide step; the denominator is total_cnt, which is frozen during DIVIDE.
   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      rem_sh = {rem, quo[NUM_W-1]};
      ge     = 1'b0;
      rem_nx = rem_sh[CNT_W-1:0];
      if (rem_sh >= {1'b0, total_cnt}) begin
         ge     = 1'b1;
         // The true difference is below total_cnt, so it fits without the shifted-out MSB.
         rem_nx = rem_sh[CNT_W-1:0] - total_cnt;
      end
      quo_nx = {quo[NUM_W-2:0], ge};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         smp.in_ready <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         total_cnt    <= '0;
         correct_cnt  <= '0;
         acc_bp       <= '0;
         quo          <= '0;
         rem          <= '0;
         div_cnt      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= COUNT;
                  smp.in_ready <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  total_cnt    <= '0;
                  correct_cnt  <= '0;
                  acc_bp       <= '0;
               end
            end
            COUNT: begin
               if (accept) begin
                  total_cnt   <= total_inc;
                  correct_cnt <= correct_inc;
                  if (pass_end) begin
                     state        <= DIVIDE;
                     smp.in_ready <= 1'b0;
                     quo          <= NUM_W'(correct_inc) * BP_SCALE;
                     rem          <= '0;
                     div_cnt      <= '0;
                  end
               end
            end
            DIVIDE: begin
               quo     <= quo_nx;
               rem     <= rem_nx;
               div_cnt <= div_cnt + DIV_CW'(1);
               if (div_cnt == DIV_LAST) begin
                  acc_bp <= quo_nx[ACC_W-1:0];
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
